stepper_phase_ctrl: RTL and testbench

Parametrised two-coil stepper phase controller. It replaces the fixed full-step motor block and drives a dual H-bridge (IN1/IN2 per coil, standby) plus a PWM current reference. Step pulses arrive asynchronously; they are synchronised, divided by a runtime ratio and used to advance an 8-entry half-step table, in half-step or full-step mode. The block tracks signed position and drops to a reduced hold current after a programmable idle time.

---
 rtl/stepper_phase_ctrl.sv | 152 +++++++++++++++
 tb/tb_stepper_phase_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stepper_phase_ctrl.sv
// Two-coil stepper phase controller: synchronised step/dir input, step divider,
// 8-entry half-step table, signed position tracking, idle hold current and PWM reference.
module stepper_phase_ctrl #(
  parameter int PWM_W  = 4,
  parameter int DIV_W  = 4,
  parameter int POS_W  = 16,
  parameter int IDLE_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              step_in,
  input  logic              dir,
  input  logic              half_step,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [PWM_W-1:0]  run_level,
  input  logic [PWM_W-1:0]  hold_level,
  input  logic [IDLE_W-1:0] idle_timeout,
  output logic              ina1,
  output logic              ina2,
  output logic              inb1,
  output logic              inb2,
  output logic              stby,
  output logic              vref_pwm,
  output logic [POS_W-1:0]  position,
  output logic              holding,
  output logic [2:0]        phase_idx
);

  localparam logic [2:0]       IDX_RESET = 3'd1;
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [PWM_W-1:0] PWM_ONE   = PWM_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

  // Coil drive per table index as {a_in1, a_in2, b_in1, b_in2}; 00 on a coil means coast.
  function automatic logic [3:0] coil_drive(input logic [2:0] idx);
    logic [3:0] drv;
    drv = 4'b0000;
    case (idx)
      3'd0: drv = 4'b10_00;
      3'd1: drv = 4'b10_10;
      3'd2: drv = 4'b00_10;
      3'd3: drv = 4'b01_10;
      3'd4: drv = 4'b01_00;
      3'd5: drv = 4'b01_01;
      3'd6: drv = 4'b00_01;
      3'd7: drv = 4'b10_01;
      default: drv = 4'b0000;
    endcase
    return drv;
  endfunction

  logic [2:0]        step_sync;
  logic [1:0]        dir_sync;
  logic [DIV_W-1:0]  div_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [PWM_W-1:0]  lvl_q;

  logic              step_ev;
  logic              dir_fwd;
  logic              advance;
  logic [1:0]        step_mag;
  logic [2:0]        idx_next;
  logic [POS_W-1:0]  mag_ext;
  logic [POS_W-1:0]  pos_next;
  logic [PWM_W-1:0]  eff_level;

  // Step edge is detected between sync2 and sync3; only sync2 of dir is consumed,
  // so dir needs no third stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sync <= 3'b000;
      dir_sync  <= 2'b00;
    end else begin
      step_sync <= {step_sync[1:0], step_in};
      dir_sync  <= {dir_sync[0], dir};
    end
  end

  always_comb begin
    step_ev  = step_sync[1] & ~step_sync[2];
    dir_fwd  = dir_sync[1];
    advance  = enable & step_ev & (div_cnt == step_div);
    // Full-step from an even index moves one half-step, landing on the two-coil-on odd entries.
    step_mag = (half_step || !phase_idx[0]) ? 2'd1 : 2'd2;
    idx_next = dir_fwd ? (phase_idx + {1'b0, step_mag}) : (phase_idx - {1'b0, step_mag});
    mag_ext  = {{(POS_W-2){1'b0}}, step_mag};
    pos_next = dir_fwd ? (position + mag_ext) : (position - mag_ext);
    eff_level = holding ? hold_level : run_level;
  end

  // A step_div lowered below div_cnt lets div_cnt run through its natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
    end else if (step_ev) begin
      if (div_cnt == step_div) div_cnt <= '0;
      else                     div_cnt <= div_cnt + DIV_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_idx <= IDX_RESET;
      position  <= '0;
    end else if (advance) begin
      phase_idx <= idx_next;
      position  <= pos_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (enable) begin
      if (advance)              idle_cnt <= '0;
      else if (idle_cnt != '1)  idle_cnt <= idle_cnt + IDLE_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) holding <= 1'b0;
    else        holding <= (idle_timeout != '0) && (idle_cnt >= idle_timeout);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ina1, ina2, inb1, inb2} <= 4'b0000;
      stby                     <= 1'b0;
    end else begin
      {ina1, ina2, inb1, inb2} <= enable ? coil_drive(phase_idx) : 4'b0000;
      stby                     <= enable;
    end
  end

  // Level is sampled only at the counter wrap so a change never splits a PWM period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      lvl_q    <= '0;
      vref_pwm <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + PWM_ONE;
      if (pwm_cnt == '0) lvl_q <= eff_level;
      vref_pwm <= (pwm_cnt < lvl_q);
    end
  end

endmodule

// File: tb/tb_stepper_phase_ctrl.sv
// Self-checking bench for stepper_phase_ctrl: step scoreboard, hold timing,
// PWM duty per period and enable gating.
module tb_stepper_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        step_in;
  logic        dir;
  logic        half_step;
  logic [3:0]  step_div;
  logic [3:0]  run_level;
  logic [3:0]  hold_level;
  logic [19:0] idle_timeout;
  logic        ina1, ina2, inb1, inb2;
  logic        stby;
  logic        vref_pwm;
  logic [15:0] position;
  logic        holding;
  logic [2:0]  phase_idx;

  stepper_phase_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .step_in(step_in), .dir(dir),
    .half_step(half_step), .step_div(step_div), .run_level(run_level),
    .hold_level(hold_level), .idle_timeout(idle_timeout),
    .ina1(ina1), .ina2(ina2), .inb1(inb1), .inb2(inb2), .stby(stby),
    .vref_pwm(vref_pwm), .position(position), .holding(holding), .phase_idx(phase_idx)
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  // scoreboard entry: {idx[2:0], in[3:0], pos[15:0], stby}
  logic [23:0] exp_q[$];

  // coil sign tables: +1, 0 (coast), -1
  int ca[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int cb[8] = '{0, 1, 1, 1, 0, -1, -1, -1};

  int          m_idx;
  logic [15:0] m_pos;
  int          m_div;
  logic        m_en;

  function automatic logic [3:0] exp_in(input int i);
    return {ca[i] == 1, ca[i] == -1, cb[i] == 1, cb[i] == -1};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic model_step(input logic d);
    int delta;
    if (m_en) begin
      if (m_div == int'(step_div)) begin
        m_div = 0;
        delta = (half_step || (m_idx % 2 == 0)) ? 1 : 2;
        if (!d) delta = -delta;
        m_idx = (m_idx + delta + 8) % 8;
        m_pos = m_pos + 16'(delta);
      end else begin
        m_div = (m_div + 1) % 16;
      end
    end
    exp_q.push_back({3'(m_idx), (m_en ? exp_in(m_idx) : 4'b0000), m_pos, m_en});
  endtask

  task automatic compare_head();
    logic [23:0] want;
    want = exp_q.pop_front();
    check("idx", 32'(phase_idx), 32'(want[23:21]));
    check("in", 32'({ina1, ina2, inb1, inb2}), 32'(want[20:17]));
    check("pos", 32'(position), 32'(want[16:1]));
    check("stby", 32'(stby), 32'(want[0]));
  endtask

  // driver: dir settles 3 clk before the rise, pulse high 4 clk and low 4 clk
  task automatic do_step(input logic d);
    @(negedge clk);
    dir = d;
    repeat (3) @(negedge clk);
    step_in = 1'b1;
    model_step(d);
    repeat (4) @(negedge clk);
    step_in = 1'b0;
    repeat (4) @(negedge clk);
    compare_head();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("rst_idx", 32'(phase_idx), 32'd1);
    check("rst_in", 32'({ina1, ina2, inb1, inb2}), 32'd0);
    check("rst_stby", 32'(stby), 32'd0);
    check("rst_pos", 32'(position), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_idx = 1; m_pos = '0; m_div = 0; m_en = enable;
    @(negedge clk);
    check("rel_idx", 32'(phase_idx), 32'd1);
    check("rel_in", 32'({ina1, ina2, inb1, inb2}), 32'(exp_in(1)));
    check("rel_stby", 32'(stby), 32'd1);
    check("rel_pos", 32'(position), 32'd0);
    check("rel_hold", 32'(holding), 32'd0);
    check("rel_vref", 32'(vref_pwm), 32'd0);
  endtask

  initial begin
    int win_cnt, win_len, win_exp;
    logic win_on;
    rst_n = 1'b0; enable = 1'b1; step_in = 1'b0; dir = 1'b1; half_step = 1'b1;
    step_div = 4'd0; run_level = 4'd12; hold_level = 4'd3; idle_timeout = 20'd0;

    // reset with enable high
    do_reset();

    // half-step forward, 8 pulses
    for (int i = 0; i < 8; i++) do_step(1'b1);
    check("half_pos8", 32'(position), 32'd8);

    // full-step with misalignment from index 2
    do_reset();
    do_step(1'b1);
    half_step = 1'b0;
    for (int i = 0; i < 3; i++) do_step(1'b0);
    check("full_pos", 32'(position), 32'h0000_FFFC);

    // divider: 7 pulses give 2 advances; 2 more bring the third advance
    half_step = 1'b1;
    step_div = 4'd2;
    for (int i = 0; i < 9; i++) do_step(1'b1);

    // idle/hold timing and PWM duty per period
    step_div = 4'd0;
    idle_timeout = 20'd50;
    repeat (5) @(negedge clk);
    step_in = 1'b1;
    model_step(1'b1);
    repeat (3) @(posedge clk);
    win_on = 1'b0; win_cnt = 0; win_len = 0; win_exp = 0;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clk);
      #1;
      if (n == 4) step_in = 1'b0;
      if (n <= 60) check("hold_t", 32'(holding), 32'(n >= 51));
      if (win_on) begin
        win_cnt += int'(vref_pwm);
        win_len++;
        if (win_len == 16) begin
          check("duty", 32'(win_cnt), 32'(win_exp));
          win_on = 1'b0;
        end
      end
      if ((cyc % 16 == 1) && n >= 2) begin
        win_exp = ((n - 1) >= 51) ? 3 : 12;
        win_on = 1'b1; win_cnt = 0; win_len = 0;
      end
    end
    @(negedge clk);
    compare_head();
    check("hold_on", 32'(holding), 32'd1);
    do_step(1'b1);
    check("hold_clr", 32'(holding), 32'd0);

    // disable while pulsing
    idle_timeout = 20'd0;
    @(negedge clk);
    enable = 1'b0;
    m_en = 1'b0;
    m_div = 0;
    repeat (2) @(negedge clk);
    check("dis_stby", 32'(stby), 32'd0);
    check("dis_in", 32'({ina1, ina2, inb1, inb2}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      do_step(1'b0);
      check("dis_hold", 32'(holding), 32'd0);
    end
    @(negedge clk);
    enable = 1'b1;
    m_en = 1'b1;
    @(negedge clk);
    check("en_in", 32'({ina1, ina2, inb1, inb2}), 32'(exp_in(m_idx)));
    check("en_stby", 32'(stby), 32'd1);
    do_step(1'b0);
    check("en_hold", 32'(holding), 32'd0);
    check("q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
